// File: rtl/harris_corner_reporter.sv
// Harris corner reporter: thresholds signed R per pixel, optional 1x3 horizontal NMS,
// queues corner coordinates in a FWFT FIFO and reports per-frame count/done/overflow.
module harris_corner_reporter #(
  parameter  int RW         = 64,
  parameter  int IMG_W      = 640,
  parameter  int IMG_H      = 480,
  parameter  int FIFO_DEPTH = 16,
  parameter  int NMS_EN     = 1,
  parameter  int CW         = 32,
  localparam int XW         = $clog2(IMG_W),
  localparam int YW         = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 score_valid,
  input  logic signed [RW-1:0] score,
  input  logic                 sof,
  input  logic signed [RW-1:0] threshold,
  input  logic                 cmp_ge,
  output logic                 corner_valid,
  input  logic                 corner_ready,
  output logic [XW-1:0]        corner_x,
  output logic [YW-1:0]        corner_y,
  output logic [CW-1:0]        corner_count,
  output logic                 frame_done,
  output logic                 overflow
);
  // state | meaning
  // IDLE  | waiting for a sof beat
  // RUN   | accepting pixel beats in raster order
  // FLUSH | last pixel seen; frame_done registered on exit
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  state_t               state;
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic signed [RW-1:0] thr_q;
  logic                 ge_q;

  logic                 start, beat, row_end, pass_now, ge_eff;
  logic [XW-1:0]        cur_x;
  logic [YW-1:0]        cur_y;
  logic signed [RW-1:0] thr_eff;

  // The sof beat itself is judged against the threshold arriving with it.
  assign start    = score_valid && sof;
  assign beat     = start || (score_valid && state == RUN);
  assign cur_x    = start ? '0 : x_q;
  assign cur_y    = start ? '0 : y_q;
  assign thr_eff  = start ? threshold : thr_q;
  assign ge_eff   = start ? cmp_ge : ge_q;
  assign pass_now = ge_eff ? (score >= thr_eff) : (score > thr_eff);
  assign row_end  = (cur_x == X_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      thr_q      <= '0;
      ge_q       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == FLUSH);
      if (start) begin
        thr_q <= threshold;
        ge_q  <= cmp_ge;
      end
      if (beat) begin
        x_q <= row_end ? '0 : cur_x + 1'b1;
        y_q <= row_end ? cur_y + 1'b1 : cur_y;
      end
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (beat && row_end && cur_y == Y_LAST) state <= FLUSH;
        FLUSH:   state <= start ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic          det;
  logic [XW-1:0] det_x;
  logic [YW-1:0] det_y;

  generate
    if (NMS_EN != 0) begin : g_nms
      logic                 cand_v, cand_pass, cand_gt;
      logic signed [RW-1:0] cand_r;
      logic [XW-1:0]        cand_x;
      logic [YW-1:0]        cand_y;
      logic                 gt_left, cand_hit, self_hit;

      // Candidate is always the previous pixel of the same row; sof discards it.
      assign gt_left  = (cur_x == '0) || (score > cand_r);
      assign cand_hit = beat && !start && cand_v && cand_pass && cand_gt && (cand_r >= score);
      assign self_hit = beat && row_end && pass_now && gt_left;
      assign det      = cand_hit || self_hit;
      assign det_x    = cand_hit ? cand_x : cur_x;
      assign det_y    = cand_hit ? cand_y : cur_y;

      always_ff @(posedge clk) begin
        if (!reset) begin
          cand_v    <= 1'b0;
          cand_pass <= 1'b0;
          cand_gt   <= 1'b0;
          cand_r    <= '0;
          cand_x    <= '0;
          cand_y    <= '0;
        end else if (beat) begin
          cand_v    <= !row_end;
          cand_pass <= pass_now;
          cand_gt   <= gt_left;
          cand_r    <= score;
          cand_x    <= cur_x;
          cand_y    <= cur_y;
        end
      end
    end else begin : g_thr
      assign det   = beat && pass_now;
      assign det_x = cur_x;
      assign det_y = cur_y;
    end
  endgenerate

  logic          push_q, full, pop, wr, drop;
  logic [XW-1:0] push_x;
  logic [YW-1:0] push_y;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt;
  logic [XW+YW-1:0] mem [FIFO_DEPTH];

  assign full         = (fcnt == FULL_CNT);
  assign corner_valid = (fcnt != '0);
  assign pop          = corner_valid && corner_ready;
  assign wr           = push_q && (!full || pop);
  assign drop         = push_q && full && !pop;
  assign {corner_y, corner_x} = corner_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      push_q       <= 1'b0;
      push_x       <= '0;
      push_y       <= '0;
      corner_count <= '0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fcnt         <= '0;
    end else begin
      push_q <= det;
      push_x <= det_x;
      push_y <= det_y;
      if (start)
        corner_count <= CW'(det);
      else if (det && corner_count != '1)
        corner_count <= corner_count + 1'b1;
      if (start)
        overflow <= 1'b0;
      else if (drop)
        overflow <= 1'b1;
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)
        fcnt <= fcnt + 1'b1;
      else if (pop && !wr)
        fcnt <= fcnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= {push_y, push_x};
  end
endmodule

// File: tb/tb_harris_corner_reporter.sv
// Scoreboard bench: two 4x2 reporters (threshold-only and NMS), expected corners queued
// at stimulus time and popped by per-instance monitors on valid&&ready.
module tb_harris_corner_reporter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sv0, sv1, sof, ge, rdy0, rdy1;
  logic signed [15:0] score, thr;
  logic cv0, cv1, fd0, fd1, ovf0, ovf1;
  logic [1:0] cx0, cx1;
  logic cy0, cy1;
  logic [7:0] cnt0, cnt1;

  harris_corner_reporter #(.RW(16), .IMG_W(4), .IMG_H(2), .FIFO_DEPTH(4), .NMS_EN(0), .CW(8)) u0 (
    .clk(clk), .reset(rst), .score_valid(sv0), .score(score), .sof(sof), .threshold(thr),
    .cmp_ge(ge), .corner_valid(cv0), .corner_ready(rdy0), .corner_x(cx0), .corner_y(cy0),
    .corner_count(cnt0), .frame_done(fd0), .overflow(ovf0));

  harris_corner_reporter #(.RW(16), .IMG_W(4), .IMG_H(2), .FIFO_DEPTH(4), .NMS_EN(1), .CW(8)) u1 (
    .clk(clk), .reset(rst), .score_valid(sv1), .score(score), .sof(sof), .threshold(thr),
    .cmp_ge(ge), .corner_valid(cv1), .corner_ready(rdy1), .corner_x(cx1), .corner_y(cy1),
    .corner_count(cnt1), .frame_done(fd1), .overflow(ovf1));

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt0 = 0;
  int fd_base;
  logic [2:0] exp0 [$];
  logic [2:0] exp1 [$];
  logic signed [15:0] row [8];

  function automatic logic [2:0] e(input int x, input int y);
    return {y[0], x[1:0]};
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] ex;
    if (fd0) fd_cnt0++;
    if (rst && cv0 && rdy0) begin
      n_cmp++;
      if (exp0.size() == 0) begin
        n_bad++;
        $display("FAIL pop0: got (%0d,%0d) want no entry", cx0, cy0);
      end else begin
        ex = exp0.pop_front();
        if ({cy0, cx0} !== ex) begin
          n_bad++;
          $display("FAIL pop0: got (%0d,%0d) want (%0d,%0d)", cx0, cy0, ex[1:0], ex[2]);
        end
      end
    end
    if (rst && cv1 && rdy1) begin
      n_cmp++;
      if (exp1.size() == 0) begin
        n_bad++;
        $display("FAIL pop1: got (%0d,%0d) want no entry", cx1, cy1);
      end else begin
        ex = exp1.pop_front();
        if ({cy1, cx1} !== ex) begin
          n_bad++;
          $display("FAIL pop1: got (%0d,%0d) want (%0d,%0d)", cx1, cy1, ex[1:0], ex[2]);
        end
      end
    end
  end

  // Called just after a posedge; leaves the beat sampled on the next posedge.
  task automatic send(input bit which, input bit s, input logic signed [15:0] sc);
    sv0 = !which;
    sv1 = which;
    sof = s;
    score = sc;
    @(posedge clk); #1;
    sv0 = 1'b0;
    sv1 = 1'b0;
    sof = 1'b0;
  endtask

  task automatic send_frame(input bit which);
    for (int i = 0; i < 8; i++) send(which, i == 0, row[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input bit which, input string name);
    for (int i = 0; i < 50; i++) begin
      if ((which ? exp1.size() : exp0.size()) == 0) break;
      idle(1);
    end
    check(name, which ? exp1.size() : exp0.size(), 0);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; sv0 = 1'b0; sv1 = 1'b0; sof = 1'b0; score = '0;
    thr = '0; ge = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    idle(3);
    check("rst_cv0", cv0, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_fd0", fd0, 0);
    check("rst_ovf0", ovf0, 0);
    check("rst_cv1", cv1, 0);
    rst = 1'b1;
    idle(1);

    // single corner at (1,1), frame_done timing
    thr = 100; ge = 1'b0;
    row = '{0, 0, 0, 0, 0, 150, 0, 0};
    exp0.push_back(e(1, 1));
    send_frame(0);
    check("t1_fd_early", fd0, 0);
    idle(1);
    check("t1_fd", fd0, 1);
    check("t1_cnt", cnt0, 1);
    idle(1);
    check("t1_fd_end", fd0, 0);
    wait_drain(0, "t1_drain");

    // inclusive vs strict compare, signed compare
    thr = 100; ge = 1'b1;
    row = '{100, 0, 0, 0, 0, 0, 0, 0};
    exp0.push_back(e(0, 0));
    send_frame(0);
    idle(2);
    check("t2_ge_cnt", cnt0, 1);
    wait_drain(0, "t2_ge_drain");
    ge = 1'b0;
    send_frame(0);
    idle(2);
    check("t2_gt_cnt", cnt0, 0);
    check("t2_gt_cv", cv0, 0);
    thr = -5;
    row = '{-3, 50, -10, -10, -10, -10, -10, -10};
    exp0.push_back(e(0, 0));
    exp0.push_back(e(1, 0));
    send_frame(0);
    idle(2);
    check("t2_sign_cnt", cnt0, 2);
    wait_drain(0, "t2_sign_drain");

    // NMS plateau and row edges
    thr = 100; ge = 1'b0;
    row = '{200, 300, 300, 50, 500, 0, 0, 500};
    exp1.push_back(e(1, 0));
    exp1.push_back(e(0, 1));
    exp1.push_back(e(3, 1));
    send_frame(1);
    idle(1);
    check("t3_fd", fd1, 1);
    check("t3_cnt", cnt1, 3);
    wait_drain(1, "t3_drain");

    // FIFO overflow with consumer stalled
    rdy0 = 1'b0;
    row = '{200, 200, 200, 200, 200, 200, 0, 0};
    for (int i = 0; i < 4; i++) exp0.push_back(e(i, 0));
    send_frame(0);
    idle(2);
    check("t4_ovf", ovf0, 1);
    check("t4_cnt", cnt0, 6);
    check("t4_cv", cv0, 1);
    rdy0 = 1'b1;
    wait_drain(0, "t4_drain");
    check("t4_cv_fall", cv0, 0);

    // mid-frame sof restart
    rdy0 = 1'b0;
    row = '{200, 200, 0, 0, 0, 0, 0, 0};
    exp0.push_back(e(0, 0));
    exp0.push_back(e(1, 0));
    send_frame(0);
    idle(2);
    send(0, 1, 200);
    send(0, 0, 200);
    send(0, 0, 200);
    exp0.push_back(e(0, 0));
    exp0.push_back(e(1, 0));
    idle(2);
    check("t6_ovf_set", ovf0, 1);
    check("t6_cnt_pre", cnt0, 3);
    send(0, 1, 0);
    check("t6_cnt_clr", cnt0, 0);
    check("t6_ovf_clr", ovf0, 0);
    rdy0 = 1'b1;
    fd_base = fd_cnt0;
    exp0.push_back(e(1, 1));
    for (int i = 1; i < 8; i++) send(0, 0, (i == 5) ? 16'sd200 : 16'sd0);
    check("t6_fd_early", fd_cnt0 - fd_base, 0);
    check("t6_fd_now", fd0, 0);
    idle(1);
    check("t6_fd", fd0, 1);
    check("t6_cnt", cnt0, 1);
    wait_drain(0, "t6_drain");

    // reset mid-frame with entries queued
    rdy0 = 1'b0;
    send(0, 1, 200);
    send(0, 0, 200);
    send(0, 0, 0);
    idle(2);
    check("t5_cv_pre", cv0, 1);
    check("t5_cnt_pre", cnt0, 2);
    fd_base = fd_cnt0;
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    check("t5_cv", cv0, 0);
    check("t5_cnt", cnt0, 0);
    rdy0 = 1'b1;
    send(0, 0, 200);
    send(0, 0, 200);
    send(0, 0, 200);
    idle(12);
    check("t5_ign_cv", cv0, 0);
    check("t5_ign_cnt", cnt0, 0);
    check("t5_no_fd", fd_cnt0 - fd_base, 0);
    exp0.push_back(e(0, 0));
    send(0, 1, 200);
    check("t5_sof_cnt", cnt0, 1);
    wait_drain(0, "t5_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
